suma_bcd_operandos: RTL and testbench

Consumer end of the delayed-start/operand handshake in the calculator datapath. The block detects the rising edge of the delayed start pulse and captures two 10-digit packed-BCD operands. It then adds them serially, one digit per clock from the least-significant digit, and presents a 40-bit BCD result with carry, a busy flag and a one-cycle completion pulse to the display/control logic.

---
 rtl/suma_bcd_operandos.sv | 149 ++++++++++++++
 tb/tb_suma_bcd_operandos.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/suma_bcd_operandos.sv
// Serial 10-digit packed-BCD adder: captures operands on a rising start edge and
// adds one digit per clock. Define SUMA_BCD_RESTA_EN to add the op port (A-B mode).
module suma_bcd_operandos (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [39:0] inA,
    input  logic [39:0] inB,
`ifdef SUMA_BCD_RESTA_EN
    input  logic        op,
`endif
    output logic [39:0] resultado,
    output logic        acarreo,
    output logic        ocupado,
    output logic        hecho,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [39:0] a_sh;
    logic [39:0] b_sh;
    logic [39:0] res_sh;
    logic [3:0]  idx;
    logic        carry;
    logic        err_p;
    logic        start_d;

    logic        accept;
    logic        bad_operand;
    logic [39:0] b_load;
    logic        carry_init;
    logic [4:0]  sum;
    logic [3:0]  digit;
    logic        carry_n;

    function automatic logic has_bad_nibble(input logic [39:0] v);
        logic bad;
        bad = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [39:0] nines_comp(input logic [39:0] v);
        logic [39:0] r;
        r = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        end
        return r;
    endfunction

    always_comb begin
        accept      = (state == IDLE) && start && !start_d;
        bad_operand = has_bad_nibble(inA) || has_bad_nibble(inB);
`ifdef SUMA_BCD_RESTA_EN
        // Complement is taken after the validity check so bad nibbles still flag error.
        b_load      = op ? nines_comp(inB) : inB;
        carry_init  = op;
`else
        b_load      = inB;
        carry_init  = 1'b0;
`endif
    end

    always_comb begin
        sum     = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'd0, carry};
        digit   = sum[3:0];
        carry_n = 1'b0;
        if (sum > 5'd9) begin
            digit   = sum[3:0] + 4'd6;
            carry_n = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SUMA;
            SUMA:    if (idx == 4'd9) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign ocupado = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            err_p     <= 1'b0;
            start_d   <= 1'b0;
            resultado <= '0;
            acarreo   <= 1'b0;
            hecho     <= 1'b0;
            error     <= 1'b0;
        end else begin
            start_d <= start;
            hecho   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= inA;
                        b_sh  <= b_load;
                        idx   <= '0;
                        carry <= carry_init;
                        err_p <= bad_operand;
                        error <= 1'b0;
                    end
                end
                SUMA: begin
                    a_sh   <= {4'd0, a_sh[39:4]};
                    b_sh   <= {4'd0, b_sh[39:4]};
                    res_sh <= {digit, res_sh[39:4]};
                    carry  <= carry_n;
                    if (idx != 4'd9) idx <= idx + 4'd1;
                end
                FIN: begin
                    resultado <= err_p ? '0 : res_sh;
                    acarreo   <= err_p ? 1'b0 : carry;
                    error     <= err_p;
                    hecho     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_suma_bcd_operandos.sv
// Directed self-checking bench for suma_bcd_operandos.
module tb_suma_bcd_operandos;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [39:0] inA;
    logic [39:0] inB;
`ifdef SUMA_BCD_RESTA_EN
    logic        op;
`endif
    logic [39:0] resultado;
    logic        acarreo;
    logic        ocupado;
    logic        hecho;
    logic        error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    suma_bcd_operandos dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inA       (inA),
        .inB       (inB),
`ifdef SUMA_BCD_RESTA_EN
        .op        (op),
`endif
        .resultado (resultado),
        .acarreo   (acarreo),
        .ocupado   (ocupado),
        .hecho     (hecho),
        .error     (error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle start pulse; returns edges from accept to first hecho (-1 if none within 20).
    task automatic do_op(input logic [39:0] a, input logic [39:0] b, input logic sub,
                         output int lat, output logic err_acc, output logic busy_acc);
`ifdef SUMA_BCD_RESTA_EN
        op = sub;
`else
        if (sub) $display("note: subtraction requested in add-only build");
`endif
        inA = a;
        inB = b;
        start = 1'b1;
        tick();
        err_acc  = error;
        busy_acc = ocupado;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (hecho) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        inA = '0;
        inB = '0;
`ifdef SUMA_BCD_RESTA_EN
        op = 1'b0;
`endif
        tick();
        tick();
        checks += 5;
        if (resultado !== 40'h0) begin failures++; $display("FAIL reset_resultado got=%h exp=0", resultado); end
        if (acarreo !== 1'b0) begin failures++; $display("FAIL reset_acarreo got=%b exp=0", acarreo); end
        if (ocupado !== 1'b0) begin failures++; $display("FAIL reset_ocupado got=%b exp=0", ocupado); end
        if (hecho !== 1'b0) begin failures++; $display("FAIL reset_hecho got=%b exp=0", hecho); end
        if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_add();
        int lat;
        logic ea, ba;
        do_op(40'h0000000123, 40'h0000000877, 1'b0, lat, ea, ba);
        checks += 5;
        if (ba !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", ba); end
        if (lat !== 11) begin failures++; $display("FAIL basic_latency got=%0d exp=11", lat); end
        if (resultado !== 40'h0000001000) begin failures++; $display("FAIL basic_resultado got=%h exp=0000001000", resultado); end
        if (acarreo !== 1'b0) begin failures++; $display("FAIL basic_acarreo got=%b exp=0", acarreo); end
        if (error !== 1'b0) begin failures++; $display("FAIL basic_error got=%b exp=0", error); end
        tick();
        checks += 3;
        if (hecho !== 1'b0) begin failures++; $display("FAIL basic_hecho_width got=%b exp=0", hecho); end
        if (ocupado !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", ocupado); end
        if (resultado !== 40'h0000001000) begin failures++; $display("FAIL basic_hold got=%h exp=0000001000", resultado); end
    endtask

    task automatic test_overflow();
        int lat;
        logic ea, ba;
        do_op(40'h9999999999, 40'h0000000001, 1'b0, lat, ea, ba);
        checks += 3;
        if (lat !== 11) begin failures++; $display("FAIL ovf_latency got=%0d exp=11", lat); end
        if (resultado !== 40'h0) begin failures++; $display("FAIL ovf_resultado got=%h exp=0", resultado); end
        if (acarreo !== 1'b1) begin failures++; $display("FAIL ovf_acarreo got=%b exp=1", acarreo); end
        tick();
    endtask

    task automatic test_held_start();
        int pulses = 0;
        int first = -1;
        inA = 40'h0000000045;
        inB = 40'h0000000037;
        start = 1'b1;
        tick();
        for (int n = 1; n <= 25; n++) begin
            if (n == 3) start = 1'b0;
            if (n == 5) start = 1'b1;
            if (n == 6) start = 1'b0;
            tick();
            if (n == 5) begin
                checks++;
                if (ocupado !== 1'b1) begin failures++; $display("FAIL held_busy got=%b exp=1", ocupado); end
            end
            if (hecho) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        checks += 3;
        if (pulses !== 1) begin failures++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
        if (first !== 11) begin failures++; $display("FAIL held_latency got=%0d exp=11", first); end
        if (resultado !== 40'h0000000082) begin failures++; $display("FAIL held_resultado got=%h exp=0000000082", resultado); end
    endtask

    task automatic test_invalid();
        int lat;
        logic ea, ba;
        do_op(40'h000000000A, 40'h0000000001, 1'b0, lat, ea, ba);
        checks += 4;
        if (lat !== 11) begin failures++; $display("FAIL inv_latency got=%0d exp=11", lat); end
        if (error !== 1'b1) begin failures++; $display("FAIL inv_error got=%b exp=1", error); end
        if (resultado !== 40'h0) begin failures++; $display("FAIL inv_resultado got=%h exp=0", resultado); end
        if (acarreo !== 1'b0) begin failures++; $display("FAIL inv_acarreo got=%b exp=0", acarreo); end
        tick();
        do_op(40'h0000000001, 40'h0000000001, 1'b0, lat, ea, ba);
        checks += 4;
        if (ea !== 1'b0) begin failures++; $display("FAIL inv_clear_at_accept got=%b exp=0", ea); end
        if (lat !== 11) begin failures++; $display("FAIL inv2_latency got=%0d exp=11", lat); end
        if (error !== 1'b0) begin failures++; $display("FAIL inv2_error got=%b exp=0", error); end
        if (resultado !== 40'h0000000002) begin failures++; $display("FAIL inv2_resultado got=%h exp=0000000002", resultado); end
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int lat;
        logic ea, ba;
        inA = 40'h0000000999;
        inB = 40'h0000000001;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 4; n++) tick();
        rst = 1'b1;
        tick();
        checks += 5;
        if (resultado !== 40'h0) begin failures++; $display("FAIL mid_resultado got=%h exp=0", resultado); end
        if (acarreo !== 1'b0) begin failures++; $display("FAIL mid_acarreo got=%b exp=0", acarreo); end
        if (ocupado !== 1'b0) begin failures++; $display("FAIL mid_ocupado got=%b exp=0", ocupado); end
        if (hecho !== 1'b0) begin failures++; $display("FAIL mid_hecho got=%b exp=0", hecho); end
        if (error !== 1'b0) begin failures++; $display("FAIL mid_error got=%b exp=0", error); end
        rst = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (hecho) pulses++;
        end
        checks++;
        if (pulses !== 0) begin failures++; $display("FAIL mid_no_hecho got=%0d exp=0", pulses); end
        do_op(40'h0000000045, 40'h0000000055, 1'b0, lat, ea, ba);
        checks += 2;
        if (lat !== 11) begin failures++; $display("FAIL mid_rerun_latency got=%0d exp=11", lat); end
        if (resultado !== 40'h0000000100) begin failures++; $display("FAIL mid_rerun_resultado got=%h exp=0000000100", resultado); end
        tick();
    endtask

    task automatic test_start_through_reset();
        int lat = -1;
        rst = 1'b1;
        start = 1'b1;
        inA = 40'h0000000002;
        inB = 40'h0000000003;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ocupado !== 1'b1) begin failures++; $display("FAIL str_accept got=%b exp=1", ocupado); end
        start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (hecho) begin
                lat = n;
                break;
            end
        end
        checks += 2;
        if (lat !== 11) begin failures++; $display("FAIL str_latency got=%0d exp=11", lat); end
        if (resultado !== 40'h0000000005) begin failures++; $display("FAIL str_resultado got=%h exp=0000000005", resultado); end
        tick();
    endtask

`ifdef SUMA_BCD_RESTA_EN
    task automatic test_resta();
        int lat;
        logic ea, ba;
        do_op(40'h0000000500, 40'h0000000123, 1'b1, lat, ea, ba);
        checks += 3;
        if (lat !== 11) begin failures++; $display("FAIL sub1_latency got=%0d exp=11", lat); end
        if (resultado !== 40'h0000000377) begin failures++; $display("FAIL sub1_resultado got=%h exp=0000000377", resultado); end
        if (acarreo !== 1'b1) begin failures++; $display("FAIL sub1_acarreo got=%b exp=1", acarreo); end
        tick();
        do_op(40'h0000000123, 40'h0000000500, 1'b1, lat, ea, ba);
        checks += 3;
        if (lat !== 11) begin failures++; $display("FAIL sub2_latency got=%0d exp=11", lat); end
        if (resultado !== 40'h9999999623) begin failures++; $display("FAIL sub2_resultado got=%h exp=9999999623", resultado); end
        if (acarreo !== 1'b0) begin failures++; $display("FAIL sub2_acarreo got=%b exp=0", acarreo); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_overflow();
        test_held_start();
        test_invalid();
        test_reset_mid();
        test_start_through_reset();
`ifdef SUMA_BCD_RESTA_EN
        test_resta();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
